// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered, handshaked ALU with optional iterative multiply.
//
// Purpose
//   Computes AND/OR/ADD/XOR (with optional operand inversion and carry-in),
//   logical/arithmetic shifts and, when enabled, a shift-add multiply. The
//   result and its {v,c,n,z} flags sit in a one-entry output buffer behind a
//   valid/ready port.
//
// Configuration macro
//   ALU_MUL_EN : when defined, opcode 3'b111 runs a WIDTH-cycle shift-add
//                multiply. When undefined, opcode 3'b111 completes in one
//                cycle with out = 0 and status = 4'b0001, and busy is 0.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operation request
//   in_ready   out  request can be accepted this cycle
//   data_a     in   operand A (WIDTH)
//   data_b     in   operand B (WIDTH); low SHW bits are the shift amount
//   fs         in   function select: [0] invert B, [1] invert A, [4:2] opcode
//   c0         in   adder carry-in
//   out_valid  out  out/status hold a result
//   out_ready  in   consumer takes the result
//   out        out  result (WIDTH)
//   status     out  {v, c, n, z}
//   busy       out  multiply in progress
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [4:0]       fs,
    input  logic             c0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       status,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    logic [2:0]        opcode;
    logic [SHW-1:0]    sh;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [WIDTH:0]    sum_w;
    logic signed [WIDTH-1:0] asr_w;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        alu_status;
    logic              accept;

    logic [WIDTH-1:0]  out_q, out_d;
    logic [3:0]        status_q, status_d;
    logic              out_valid_q, out_valid_d;

    assign opcode = fs[4:2];
    assign sh     = data_b[SHW-1:0];
    assign in_a   = fs[1] ? ~data_a : data_a;
    assign in_b   = fs[0] ? ~data_b : data_b;
    // Extra top bit captures the carry out of bit WIDTH-1.
    assign sum_w  = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, c0};
    assign asr_w  = $signed(data_a) >>> sh;

    // Single-cycle datapath. Opcode 3'b111 yields 0 here; with the multiplier
    // compiled in, that value is never registered.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            3'b000: alu_res = in_a & in_b;
            3'b001: alu_res = in_a | in_b;
            3'b010: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                // Overflow: operands share a sign that the result lacks.
                alu_v   = ~(in_a[WIDTH-1] ^ in_b[WIDTH-1]) &
                          (sum_w[WIDTH-1] ^ in_a[WIDTH-1]);
            end
            3'b011: alu_res = in_a ^ in_b;
            3'b100: alu_res = data_a << sh;
            3'b101: alu_res = data_a >> sh;
            3'b110: alu_res = asr_w;
            default: alu_res = '0;
        endcase
    end

    assign alu_status = {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_step;

    assign busy     = (state_q == S_MUL);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign busy = 1'b0;
`endif

    // One-entry output buffer: a held result blocks new work until consumed.
    assign in_ready  = ~busy & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign out       = out_q;
    assign status    = status_q;
    assign out_valid = out_valid_q;

    always_comb begin
        out_d       = out_q;
        status_d    = status_q;
        // A consumed result drops valid unless replaced below.
        out_valid_d = out_valid_q & ~out_ready;
`ifdef ALU_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == 3'b111) begin
                        state_d  = S_MUL;
                        mcand_d  = data_a;
                        mplier_d = data_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        out_d       = alu_res;
                        status_d    = alu_status;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                // Last multiplier bit: publish the accumulator including this
                // step's partial product. The buffer is empty here because
                // the request was only accepted once it had drained.
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    out_d       = acc_step;
                    status_d    = {2'b00, acc_step[WIDTH-1], (acc_step == '0)};
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`else
        if (accept) begin
            out_d       = alu_res;
            status_d    = alu_status;
            out_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            status_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            out_q       <= out_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq (WIDTH = 64).
// The driver pushes the reference result when a request is accepted; a
// negedge monitor pops and compares whenever a result is consumed.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    localparam int WIDTH = 64;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [4:0]       fs;
    logic             c0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_w;
    logic [3:0]       status;
    logic             busy;

    logic bp_mode;
    logic rnd_ready;
    logic ready_force;
    assign out_ready = bp_mode ? rnd_ready : ready_force;

    int checks;
    int passes;
    int cyc;
    int valid_cnt;
    logic [WIDTH+3:0] exp_q[$];
    logic             hold_q;
    logic [WIDTH+3:0] held;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .fs        (fs),
        .c0        (c0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_w),
        .status    (status),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        checks = 0; passes = 0; cyc = 0; valid_cnt = 0;
        bp_mode = 1'b0; rnd_ready = 1'b1; ready_force = 1'b1; hold_q = 1'b0;
        held = '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ready <= ($urandom_range(0, 3) != 0);
    end

    // Reference model: {v, c, n, z, result} from the arithmetic definitions.
    function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [4:0] f,
                                               input logic cin);
        logic [WIDTH-1:0] ia, ib, r;
        logic [WIDTH:0]   u;
        logic [WIDTH+1:0] s;
        logic             c, v;
        int               sh;
        ia = f[1] ? ~a : a;
        ib = f[0] ? ~b : b;
        sh = int'(b % WIDTH);
        c = 1'b0; v = 1'b0; r = '0;
        case (f[4:2])
            3'd0: r = ia & ib;
            3'd1: r = ia | ib;
            3'd2: begin
                u = {1'b0, ia} + {1'b0, ib} + cin;
                r = u[WIDTH-1:0];
                c = u[WIDTH];
                // Signed sum in two extra bits; overflow when the top two
                // result bits disagree.
                s = {ia[WIDTH-1], ia[WIDTH-1], ia} + {ib[WIDTH-1], ib[WIDTH-1], ib} + cin;
                v = (s[WIDTH] != s[WIDTH-1]);
            end
            3'd3: r = ia ^ ib;
            3'd4: r = a << sh;
            3'd5: r = a >> sh;
            3'd6: begin
                r = a;
                for (int k = 0; k < sh; k++) r = {r[WIDTH-1], r[WIDTH-1:1]};
            end
            default: begin
`ifdef ALU_MUL_EN
                r = a * b;
`else
                r = '0;
`endif
            end
        endcase
        return {v, c, r[WIDTH-1], (r == '0), r};
    endfunction

    task automatic chk(input string name, input logic [WIDTH+3:0] act,
                       input logic [WIDTH+3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: scoreboard compare on consumption, and hold stability while
    // a result waits under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
        end else begin
            if (out_valid) valid_cnt <= valid_cnt + 1;
            if (hold_q) chk("hold_stable", {status, out_w}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_result: got %h expected none", {status, out_w});
                end else begin
                    chk("scoreboard", {status, out_w}, exp_q.pop_front());
                end
            end
            hold_q <= out_valid && !out_ready;
            held   <= {status, out_w};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] f, input logic cin);
        int waited;
        waited = 0;
        data_a = a; data_b = b; fs = f; c0 = cin; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, f, cin));
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waited++;
            if (waited > 500) begin
                checks++;
                $display("FAIL accept_timeout: got no in_ready expected acceptance");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out"},      {4'b0, out_w},       '0);
        chk({tag, "_status"},   {64'b0, status},     '0);
        chk({tag, "_valid"},    {67'b0, out_valid},  '0);
        chk({tag, "_busy"},     {67'b0, busy},       '0);
        chk({tag, "_in_ready"}, {67'b0, in_ready},   68'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        logic [4:0]       f;
        logic [WIDTH+3:0] bp_exp;
        int n, cs, vs;

        rst_n = 1'b0; in_valid = 1'b0; data_a = '0; data_b = '0; fs = '0; c0 = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0);
        chk("add_ovf_valid", {67'b0, out_valid}, 68'd1);
        chk("add_ovf", {status, out_w}, {4'b1010, 64'h8000_0000_0000_0000});
        issue(64'd5, 64'd5, 5'b01001, 1'b1);
        chk("sub_equal", {status, out_w}, {4'b0101, 64'h0});
        issue(64'h8000_0000_0000_0000, 64'd63, 5'b11000, 1'b0);
        chk("asr63", {status, out_w}, {4'b0010, 64'hFFFF_FFFF_FFFF_FFFF});
        issue(64'h8000_0000_0000_0000, 64'd63, 5'b10100, 1'b0);
        chk("lsr63", {status, out_w}, {4'b0000, 64'h1});

`ifdef ALU_MUL_EN
        issue(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'b11100, 1'b0);
        chk("mul_busy", {67'b0, busy}, 68'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n > 200) break;
            n++;
        end
        chk("mul_ready_low", 68'(n), 68'd64);
        chk("mul_valid", {67'b0, out_valid}, 68'd1);
        chk("mul_res", {status, out_w}, {4'b0010, 64'hFFFF_FFFF_FFFF_FFFD});
        @(posedge clk); #1;
`else
        issue(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'b11100, 1'b0);
        chk("mul_off_valid", {67'b0, out_valid}, 68'd1);
        chk("mul_off_res", {status, out_w}, {4'b0001, 64'h0});
`endif
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: result held, second op refused for three cycles.
        ready_force = 1'b0;
        issue(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 5'b00110, 1'b0);
        bp_exp = model(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 5'b00110, 1'b0);
        data_a = 64'd9; data_b = 64'd1; fs = 5'b01000; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {67'b0, in_ready}, 68'd0);
            chk("bp_hold", {status, out_w}, bp_exp);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ready_force = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", {67'b0, out_valid}, 68'd0);

        // Back-to-back throughput with no backpressure.
        cs = cyc; vs = valid_cnt;
        for (int i = 0; i < 8; i++) begin
            f = 5'($urandom_range(0, 23));
            issue({$urandom(), $urandom()}, {$urandom(), $urandom()}, f, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        chk("tput_cycles", 68'(cyc - cs), 68'd9);
        chk("tput_valid", 68'(valid_cnt - vs), 68'd8);

        // Randomized traffic with random backpressure.
        bp_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0: b = 64'($urandom_range(0, WIDTH - 1));
                1: a = {1'b1, a[WIDTH-2:0]};
                2: b = a;
                default: ;
            endcase
            f = 5'($urandom_range(0, 31));
            if (f[4:2] == 3'b111 && $urandom_range(0, 3) != 0) f[4:2] = 3'b010;
            issue(a, b, f, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        bp_mode = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 68'(exp_q.size()), 68'd0);

        // Reset in the middle of an operation.
`ifdef ALU_MUL_EN
        issue(64'd7, 64'd11, 5'b11100, 1'b0);
        repeat (9) @(posedge clk);
        #1;
`else
        ready_force = 1'b0;
        issue(64'd7, 64'd11, 5'b01000, 1'b0);
`endif
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        ready_force = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_valid", {67'b0, out_valid}, 68'd0);
        chk("post_reset_busy", {67'b0, busy}, 68'd0);
        issue(64'd7, 64'd11, 5'b01000, 1'b0);
        chk("post_reset_op", {status, out_w}, {4'b0000, 64'd18});
        repeat (3) @(posedge clk);
        #1;
        chk("final_drain", 68'(exp_q.size()), 68'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
